// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// Holds the FSM state encoding and the default reset/trap addresses.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES        = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC   = 32'h0000_0100;

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns pc, runs the imem req/gnt/rvalid handshake, hands words to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN sends misaligned redirects to TRAP_VEC and pulses fetch_fault.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
`ifdef FETCH_MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
`endif
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        fetch_fault
);

  fetch_state_e state;
  fetch_state_e state_next;
  logic         kill;
  logic [31:0]  redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;

  assign misaligned      = (redirect_pc[1:0] != 2'b00);
  assign redirect_target = misaligned ? TRAP_VEC : redirect_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_fault <= 1'b0;
    end else begin
      fetch_fault <= redirect_valid && misaligned;
    end
  end
`else
  assign redirect_target = redirect_pc & ~32'h0000_0003;
  assign fetch_fault     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A redirect only changes the path out of WAIT/HOLD; REQ keeps requesting with the new pc.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = REQ;
      REQ:  if (imem_gnt) state_next = WAIT;
      WAIT: if (imem_rvalid) state_next = (redirect_valid || kill) ? REQ : HOLD;
      HOLD: if (redirect_valid || instr_ready) state_next = REQ;
    endcase
  end

  always_comb begin
    imem_req    = (state == REQ);
    instr_valid = (state == HOLD);
  end

  assign imem_addr = pc;

  // kill marks an in-flight response that belongs to a superseded pc and must be dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_ADDR;
      instr    <= 32'h0;
      instr_pc <= 32'h0;
      kill     <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_target;
      end else if (state == HOLD && instr_ready) begin
        pc <= pc + INSTR_BYTES;
      end

      if (state == REQ && imem_gnt && redirect_valid) begin
        kill <= 1'b1;
      end else if (state == WAIT) begin
        if (imem_rvalid) begin
          kill <= 1'b0;
        end else if (redirect_valid) begin
          kill <= 1'b1;
        end
      end

      if (state == WAIT && imem_rvalid && !redirect_valid && !kill) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then randomized traffic vs. a pc/memory model.
// Honours FETCH_MISALIGN_TRAP_EN to pick the expected misaligned-redirect behaviour.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  // Reference model: the pc of the instruction the sequencer should be working on.
  logic [31:0] exp_pc;
  int          hold_low;
  logic        exp_fault;

  // Memory model: at most one outstanding granted request.
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  int          gnt_pct   = 100;
  int          rv_min    = 1;
  int          rv_max    = 1;
  int          ready_pct = 100;
  int          redir_pct = 0;
  int          stray_pct = 0;
  int          force_ready = -1;
  bit          force_redir = 0;
  logic [31:0] force_target = 32'h0;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic EXP_MIS_FAULT = 1'b1;
`else
  localparam logic EXP_MIS_FAULT = 1'b0;
`endif

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .fetch_fault    (fetch_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=no finish required=finish before 1000000");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
  endfunction

  function automatic logic [31:0] effTarget(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return (t % 4 != 0) ? 32'h0000_0100 : t;
`else
    return t - (t % 4);
`endif
  endfunction

  function automatic logic faultFor(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return (t % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    exp_pc    = 32'h0;
    hold_low  = 0;
    exp_fault = 1'b0;
    pend      = 0;
    pend_cnt  = 0;
  endtask

  task automatic zeroInputs();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  task automatic checkResetValues();
    checkEq("rst_pc", pc, 32'h0);
    checkEq("rst_req", imem_req, 0);
    checkEq("rst_valid", instr_valid, 0);
    checkEq("rst_fault", fetch_fault, 0);
    checkEq("rst_instr", instr, 32'h0);
    checkEq("rst_instr_pc", instr_pc, 32'h0);
  endtask

  task automatic checkOutput();
    checkEq("pc", pc, exp_pc);
    checkEq("fault", fetch_fault, exp_fault);
    checkEq("req_valid_excl", imem_req & instr_valid, 0);
    if (imem_req) checkEq("imem_addr", imem_addr, exp_pc);
    if (hold_low > 0) checkEq("valid_gap", instr_valid, 0);
    if (instr_valid) begin
      checkEq("instr_pc", instr_pc, exp_pc);
      checkEq("instr", instr, memWord(exp_pc));
    end
  endtask

  task automatic applyStimulus();
    logic        rdy;
    logic        do_redir;
    logic        g;
    logic [31:0] tgt;
    rdy      = (force_ready >= 0) ? force_ready[0] : (int'($urandom_range(99)) < ready_pct);
    do_redir = force_redir ? 1'b1 : (int'($urandom_range(99)) < redir_pct);
    if (force_redir) tgt = force_target;
    else if ($urandom_range(9) == 0) tgt = $urandom;
    else tgt = $urandom & 32'hFFFF_FFFC;
    g = imem_req && (int'($urandom_range(99)) < gnt_pct);

    if (pend && pend_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(pend_addr);
      pend        = 0;
    end else if (pend) begin
      pend_cnt--;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = (int'($urandom_range(99)) < stray_pct);
      imem_rdata  = $urandom;
    end
    if (g) begin
      pend      = 1;
      pend_addr = imem_addr;
      pend_cnt  = int'($urandom_range(rv_max, rv_min)) - 1;
    end

    imem_gnt       = g;
    instr_ready    = rdy;
    redirect_valid = do_redir;
    redirect_pc    = do_redir ? tgt : $urandom;

    exp_fault = do_redir && faultFor(tgt);
    if (do_redir) begin
      exp_pc   = effTarget(tgt);
      hold_low = 2;
    end else if (instr_valid && rdy) begin
      exp_pc   = exp_pc + 32'd4;
      hold_low = 2;
    end else if (hold_low > 0) begin
      hold_low--;
    end
    force_ready = -1;
    force_redir = 0;
  endtask

  // Returns at the sample point where the event is seen, before that cycle's inputs are driven.
  task automatic waitFor(input int kind, input int budget, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      checkOutput();
      if ((kind == 0 && instr_valid === 1'b1) || (kind == 1 && imem_req === 1'b1)) begin
        hit = 1;
        break;
      end
      applyStimulus();
    end
    total++;
    assert (hit) else begin
      bad++;
      $error("[TB] FAIL timeout_%s: observed=no event expected=event within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    logic [31:0] held;
    int k;
    reset = 1'b1;
    zeroInputs();
    clearModel();
    #1;
    checkResetValues();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("[TB] prompt memory throughput");
    k = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      checkOutput();
      if (instr_valid) begin
        checkEq("tp_cycle", cyc, 2 + 3 * k);
        checkEq("tp_pc", instr_pc, 4 * k);
        k++;
      end
      applyStimulus();
    end
    checkEq("tp_count", k, 4);

    $display("[TB] decode stall in HOLD");
    waitFor(0, 20, "hold_valid");
    held = exp_pc;
    for (int i = 0; i < 5; i++) begin
      force_ready = 0;
      applyStimulus();
      @(negedge clk);
      checkOutput();
      checkEq("hold_valid", instr_valid, 1);
      checkEq("hold_instr_pc", instr_pc, held);
      checkEq("hold_no_req", imem_req, 0);
    end
    force_ready = 1;
    applyStimulus();
    waitFor(1, 20, "after_hold");
    checkEq("after_hold_addr", imem_addr, held + 32'd4);

    $display("[TB] redirect while waiting for memory");
    rv_min = 3;
    rv_max = 3;
    applyStimulus();
    @(negedge clk);
    checkOutput();
    checkEq("wait_no_req", imem_req, 0);
    force_redir  = 1;
    force_target = 32'h0000_0200;
    applyStimulus();
    rv_min = 1;
    rv_max = 1;
    waitFor(0, 30, "redir_wait");
    checkEq("redir_wait_pc", instr_pc, 32'h0000_0200);
    checkEq("redir_wait_instr", instr, memWord(32'h0000_0200));

    $display("[TB] redirect coincident with ready");
    force_redir  = 1;
    force_target = 32'h0000_0010;
    applyStimulus();
    waitFor(0, 30, "hold_at_10");
    checkEq("hold_at_10_pc", instr_pc, 32'h0000_0010);
    force_ready  = 1;
    force_redir  = 1;
    force_target = 32'h0000_0040;
    applyStimulus();
    waitFor(1, 20, "redir_hold");
    checkEq("redir_hold_addr", imem_addr, 32'h0000_0040);

    $display("[TB] pc wrap");
    force_redir  = 1;
    force_target = 32'hFFFF_FFFC;
    applyStimulus();
    waitFor(0, 30, "wrap_hold");
    checkEq("wrap_hold_pc", instr_pc, 32'hFFFF_FFFC);
    force_ready = 1;
    applyStimulus();
    waitFor(1, 20, "wrap_req");
    checkEq("wrap_addr", imem_addr, 32'h0000_0000);

    $display("[TB] misaligned redirect");
    gnt_pct      = 0;
    force_redir  = 1;
    force_target = 32'h0000_0103;
    applyStimulus();
    @(negedge clk);
    checkOutput();
    checkEq("mis_req", imem_req, 1);
    checkEq("mis_addr", imem_addr, 32'h0000_0100);
    checkEq("mis_fault", fetch_fault, EXP_MIS_FAULT);
    applyStimulus();
    @(negedge clk);
    checkOutput();
    checkEq("mis_fault_clear", fetch_fault, 0);
    gnt_pct = 100;
    applyStimulus();

    $display("[TB] reset mid-handshake");
    waitFor(1, 20, "pre_reset_req");
    rv_min = 4;
    rv_max = 4;
    applyStimulus();
    @(negedge clk);
    checkOutput();
    #2;
    reset = 1'b1;
    zeroInputs();
    #1;
    checkResetValues();
    clearModel();
    rv_min = 1;
    rv_max = 1;
    @(negedge clk);
    reset = 1'b0;
    force_redir  = 1;
    force_target = 32'h0000_0080;
    applyStimulus();
    waitFor(0, 20, "idle_redir");
    checkEq("idle_redir_pc", instr_pc, 32'h0000_0080);

    $display("[TB] randomized traffic");
    gnt_pct   = 60;
    rv_min    = 1;
    rv_max    = 4;
    ready_pct = 60;
    redir_pct = 8;
    stray_pct = 3;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      @(negedge clk);
      checkOutput();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
